// File: rtl/inst_loader.sv
// inst_loader: assembles a length-prefixed serial byte stream into 32-bit words and writes them to instruction RAM (optional trailing checksum under CHECKSUM_EN)
module inst_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA,
`ifdef CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;
  localparam state_t FIN =
`ifdef CHECKSUM_EN
    CHK;
`else
    DONE;
`endif
  localparam logic [CNT_W:0] CAP = (CNT_W+1)'(1) << (ADDR_W-2);
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d, wl_q, wl_d, n;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;
  logic                mem_we_q, mem_we_d, acc;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
`ifdef CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif
  assign busy         = state_q inside {LEN_HI, LEN_LO, DATA
`ifdef CHECKSUM_EN
                                        , CHK
`endif
                                        };
  assign rx_ready     = busy;
  assign done         = state_q == DONE;
  assign error        = state_q == ERR;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = wl_q;
  // next-state: header parse, word assembly, write strobe and word counting
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wl_d        = mem_we_q ? wl_q + CNT_W'(1) : wl_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef CHECKSUM_EN
    sum_d       = sum_q;
`endif
    acc         = rx_valid & rx_ready;
    n           = {len_q[CNT_W-9:0], rx_data};
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d    = LEN_HI;
        wl_d       = '0;
        byte_cnt_d = '0;
        shift_d    = '0;
`ifdef CHECKSUM_EN
        sum_d      = '0;
`endif
      end
      LEN_HI: if (acc) begin
        len_d   = CNT_W'(rx_data);
        state_d = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d   = n;
        state_d = ({1'b0, n} > CAP) ? ERR : (n == '0) ? FIN : DATA;
      end
      DATA: if (acc) begin
        shift_d    = {shift_q[15:0], rx_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CHECKSUM_EN
        sum_d      = sum_q + rx_data;
`endif
        if (byte_cnt_q == 2'd3) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {wl_q[ADDR_W-3:0], 2'b00};
          mem_wdata_d = {shift_q, rx_data};
          state_d     = (wl_q + CNT_W'(1) == len_q) ? FIN : DATA;
        end
      end
`ifdef CHECKSUM_EN
      CHK: if (acc) state_d = (rx_data == sum_q) ? DONE : ERR;
`endif
      default: ;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wl_q        <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wl_q        <= wl_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end
endmodule
